// File: rtl/skid_buffer.sv
// Two-entry skid buffer between a valid/ready producer and consumer.
// InReady depends on occupancy only, so OutReady never reaches it combinationally.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  input  logic [WIDTH-1:0] InData,
  output logic             InReady,
  output logic             OutValid,
  output logic [WIDTH-1:0] OutData,
  input  logic             OutReady,
  input  logic             Flush,
  output logic [1:0]       Count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] skid;
  logic             acc;
  logic             dlv;

  // Handshakes seen this cycle, both from registered flags.
  assign acc = InValid & InReady;
  assign dlv = OutValid & OutReady;

  // Occupancy FSM with registered flags and the two data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      InReady  <= 1'b1;
      OutValid <= 1'b0;
      Count    <= 2'd0;
      OutData  <= '0;
      skid     <= '0;
    end else if (Flush) begin
      state    <= EMPTY;
      InReady  <= 1'b1;
      OutValid <= 1'b0;
      Count    <= 2'd0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state    <= ONE;
            OutData  <= InData;
            OutValid <= 1'b1;
            InReady  <= 1'b1;
            Count    <= 2'd1;
          end
        end
        ONE: begin
          if (acc && dlv) begin
            OutData <= InData;
          end else if (acc) begin
            state   <= FULL;
            skid    <= InData;
            InReady <= 1'b0;
            Count   <= 2'd2;
          end else if (dlv) begin
            state    <= EMPTY;
            OutValid <= 1'b0;
            Count    <= 2'd0;
          end
        end
        FULL: begin
          if (dlv) begin
            state   <= ONE;
            OutData <= skid;
            InReady <= 1'b1;
            Count   <= 2'd1;
          end
        end
        default: begin
          state    <= EMPTY;
          InReady  <= 1'b1;
          OutValid <= 1'b0;
          Count    <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skid_buffer.sv
// Scoreboard bench for skid_buffer: directed beats with hand-computed
// expected output order, checked by an independent output monitor.
module tb_skid_buffer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         InValid;
  logic [W-1:0] InData;
  logic         InReady;
  logic         OutValid;
  logic [W-1:0] OutData;
  logic         OutReady;
  logic         Flush;
  logic [1:0]   Count;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] sb[$];

  skid_buffer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .InValid  (InValid),
    .InData   (InData),
    .InReady  (InReady),
    .OutValid (OutValid),
    .OutData  (OutData),
    .OutReady (OutReady),
    .Flush    (Flush),
    .Count    (Count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every delivered beat must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && OutValid && OutReady) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got %0h expected none", OutData);
      end else begin
        logic [W-1:0] e;
        e = sb.pop_front();
        if (OutData !== e) begin
          miscompares++;
          $display("FAIL out_data: got %0h expected %0h", OutData, e);
        end
      end
    end
  end

  initial begin
    InValid  = 1'b0;
    InData   = '0;
    OutReady = 1'b0;
    Flush    = 1'b0;
    reset    = 1'b0;
    #1 reset = 1'b1;
    tick();
    tick();
    chk("rst_count", int'(Count), 0);
    chk("rst_outvalid", int'(OutValid), 0);
    chk("rst_inready", int'(InReady), 1);
    chk("rst_outdata", int'(OutData), 'h00);
    #2 reset = 1'b0;
    tick();

    // single beat
    InValid = 1'b1; InData = 8'h5A; OutReady = 1'b1;
    sb.push_back(8'h5A);
    tick();
    InValid = 1'b0;
    chk("single_valid", int'(OutValid), 1);
    chk("single_data", int'(OutData), 'h5A);
    chk("single_count1", int'(Count), 1);
    tick();
    chk("single_count0", int'(Count), 0);

    // backpressure fill
    OutReady = 1'b0;
    InValid = 1'b1; InData = 8'h11;
    tick();
    InData = 8'h22;
    tick();
    InData = 8'h33;
    tick();
    chk("bp_count", int'(Count), 2);
    chk("bp_inready", int'(InReady), 0);
    chk("bp_outdata", int'(OutData), 'h11);
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    sb.push_back(8'h33);
    OutReady = 1'b1;
    tick();
    chk("bp_drain1", int'(OutData), 'h22);
    tick();
    InValid = 1'b0;
    chk("bp_drain2", int'(OutData), 'h33);
    tick();
    chk("bp_empty", int'(Count), 0);

    // streaming
    OutReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      InValid = 1'b1; InData = W'(i);
      sb.push_back(W'(i));
      tick();
      chk("stream_valid", int'(OutValid), 1);
      chk("stream_data", int'(OutData), i);
      chk("stream_count", int'(Count), 1);
    end
    InValid = 1'b0;
    tick();
    chk("stream_end", int'(Count), 0);

    // flush while full with a beat offered
    OutReady = 1'b0;
    InValid = 1'b1; InData = 8'hA1;
    tick();
    InData = 8'hA2;
    tick();
    chk("fl_full", int'(Count), 2);
    Flush = 1'b1; InData = 8'h44;
    tick();
    Flush = 1'b0; InValid = 1'b0;
    chk("fl_count", int'(Count), 0);
    chk("fl_outvalid", int'(OutValid), 0);
    chk("fl_inready", int'(InReady), 1);
    OutReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_quiet", int'(OutValid), 0);
    end

    // async reset between edges while holding one beat
    OutReady = 1'b0;
    InValid = 1'b1; InData = 8'h77;
    tick();
    InValid = 1'b0;
    chk("ar_one", int'(Count), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_outvalid", int'(OutValid), 0);
    chk("ar_count", int'(Count), 0);
    chk("ar_inready", int'(InReady), 1);
    chk("ar_outdata", int'(OutData), 'h00);
    #1 reset = 1'b0;
    tick();

    // operation resumes after reset
    OutReady = 1'b1;
    InValid = 1'b1; InData = 8'h3C;
    sb.push_back(8'h3C);
    tick();
    InValid = 1'b0;
    chk("post_rst_data", int'(OutData), 'h3C);

    // bounded drain of the scoreboard
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
